// File: rtl/ram_rr_arbiter.sv
// rtl/ram_rr_arbiter.sv - round-robin arbiter of several hosts onto one RAM-style device port
//
// Purpose: picks one requesting host per cycle by round-robin priority and
// forwards its request to the device with no added latency. The index of
// every accepted request is recorded in an order FIFO. Each device response
// is sent back to the host at the head of that FIFO.
//
// Ports:
//   clk_i, rst_ni                    clock, synchronous active-low reset
//   host_req_i / host_gnt_o          per-host request and combinational grant
//   host_addr_i, host_we_i,          per-host request fields, host i in slice i
//   host_be_i, host_wdata_i
//   host_rvalid_o, host_err_o        per-host response strobes (one-hot or zero)
//   host_rdata_o                     shared response data (zero when idle)
//   dev_req_o .. dev_wdata_o         forwarded request (all zero when idle)
//   dev_gnt_i, dev_rvalid_i,         device handshake and response
//   dev_err_i, dev_rdata_i
//   outstanding_o                    accepted requests still awaiting a response
//   spurious_rsp_o                   sticky: response arrived with nothing outstanding

module ram_rr_arbiter #(
   parameter int unsigned NrHosts        = 3,
   parameter int unsigned AddrWidth      = 32,
   parameter int unsigned DataWidth      = 32,
   parameter int unsigned MaxOutstanding = 2
) (
   input  logic                           clk_i,
   input  logic                           rst_ni,
   input  logic [NrHosts-1:0]             host_req_i,
   output logic [NrHosts-1:0]             host_gnt_o,
   input  logic [NrHosts*AddrWidth-1:0]   host_addr_i,
   input  logic [NrHosts-1:0]             host_we_i,
   input  logic [NrHosts*4-1:0]           host_be_i,
   input  logic [NrHosts*DataWidth-1:0]   host_wdata_i,
   output logic [NrHosts-1:0]             host_rvalid_o,
   output logic [DataWidth-1:0]           host_rdata_o,
   output logic [NrHosts-1:0]             host_err_o,
   output logic                           dev_req_o,
   output logic                           dev_we_o,
   output logic [AddrWidth-1:0]           dev_addr_o,
   output logic [3:0]                     dev_be_o,
   output logic [DataWidth-1:0]           dev_wdata_o,
   input  logic                           dev_gnt_i,
   input  logic                           dev_rvalid_i,
   input  logic                           dev_err_i,
   input  logic [DataWidth-1:0]           dev_rdata_i,
   output logic [$clog2(MaxOutstanding+1)-1:0] outstanding_o,
   output logic                           spurious_rsp_o
);

   localparam int unsigned IdxW = $clog2(NrHosts);
   localparam int unsigned CntW = $clog2(MaxOutstanding+1);
   // A single-entry FIFO still needs a one-bit pointer so the vectors are legal.
   localparam int unsigned PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;

   logic [IdxW-1:0] rr_ptr;
   logic [IdxW-1:0] sel_idx;
   logic            sel_found;
   int unsigned     cand;

   logic [IdxW-1:0] fifo_q [MaxOutstanding];
   logic [PtrW-1:0] rd_ptr;
   logic [PtrW-1:0] wr_ptr;
   logic [CntW-1:0] count_q;
   logic            fifo_empty;
   logic [IdxW-1:0] head_idx;

   logic            issue_ok;
   logic            accept;
   logic            pop;

   function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
      return (p == PtrW'(MaxOutstanding - 1)) ? '0 : p + PtrW'(1);
   endfunction

   // Round-robin search: the host just after the last granted one goes first.
   always_comb begin
      sel_idx   = rr_ptr;
      sel_found = 1'b0;
      cand      = 0;
      for (int unsigned k = 1; k <= NrHosts; k++) begin
         cand = (32'(rr_ptr) + k) % NrHosts;
         if (!sel_found && host_req_i[cand]) begin
            sel_idx   = IdxW'(cand);
            sel_found = 1'b1;
         end
      end
   end

   assign fifo_empty = (count_q == '0);
   assign head_idx   = fifo_q[rd_ptr];

   // A response in the same cycle frees a slot, so a full FIFO can still
   // accept a request.
   assign issue_ok = (count_q < CntW'(MaxOutstanding)) | dev_rvalid_i;
   assign accept   = dev_req_o & dev_gnt_i;
   assign pop      = rst_ni & dev_rvalid_i & ~fifo_empty;

   always_comb begin
      dev_req_o   = rst_ni & sel_found & issue_ok;
      dev_we_o    = 1'b0;
      dev_addr_o  = '0;
      dev_be_o    = '0;
      dev_wdata_o = '0;
      if (dev_req_o) begin
         dev_we_o    = host_we_i[sel_idx];
         dev_addr_o  = host_addr_i[sel_idx*AddrWidth +: AddrWidth];
         dev_be_o    = host_be_i[sel_idx*4 +: 4];
         dev_wdata_o = host_wdata_i[sel_idx*DataWidth +: DataWidth];
      end
   end

   always_comb begin
      host_gnt_o    = '0;
      host_rvalid_o = '0;
      host_err_o    = '0;
      for (int i = 0; i < NrHosts; i++) begin
         host_gnt_o[i]    = accept && (sel_idx == IdxW'(i));
         host_rvalid_o[i] = pop && (head_idx == IdxW'(i));
         host_err_o[i]    = pop && dev_err_i && (head_idx == IdxW'(i));
      end
   end

   assign host_rdata_o  = pop ? dev_rdata_i : '0;
   assign outstanding_o = count_q;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         rr_ptr         <= IdxW'(NrHosts - 1);
         rd_ptr         <= '0;
         wr_ptr         <= '0;
         count_q        <= '0;
         spurious_rsp_o <= 1'b0;
      end else begin
         if (accept) begin
            rr_ptr <= sel_idx;
            wr_ptr <= ptr_inc(wr_ptr);
         end
         if (pop) begin
            rd_ptr <= ptr_inc(rd_ptr);
         end
         if (accept && !pop) begin
            count_q <= count_q + CntW'(1);
         end else if (pop && !accept) begin
            count_q <= count_q - CntW'(1);
         end
         if (dev_rvalid_i && fifo_empty) begin
            spurious_rsp_o <= 1'b1;
         end
      end
   end

   // Storage needs no reset: entries are only read behind the count.
   always_ff @(posedge clk_i) begin
      if (accept) begin
         fifo_q[wr_ptr] <= sel_idx;
      end
   end

endmodule

// File: tb/tb_ram_rr_arbiter.sv
// tb/tb_ram_rr_arbiter.sv - self-checking bench for ram_rr_arbiter

module tb_ram_rr_arbiter;

   localparam int N  = 3;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int MO = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic            rst_n = 1'b0;
   logic [N-1:0]    host_req = '0;
   logic [N-1:0]    host_gnt;
   logic [N*AW-1:0] host_addr;
   logic [N-1:0]    host_we;
   logic [N*4-1:0]  host_be;
   logic [N*DW-1:0] host_wdata;
   logic [N-1:0]    host_rvalid;
   logic [DW-1:0]   host_rdata;
   logic [N-1:0]    host_err;
   logic            dev_req;
   logic            dev_we;
   logic [AW-1:0]   dev_addr;
   logic [3:0]      dev_be;
   logic [DW-1:0]   dev_wdata;
   logic            dev_gnt = 1'b0;
   logic            dev_rvalid = 1'b0;
   logic            dev_err = 1'b0;
   logic [DW-1:0]   dev_rdata = '0;
   logic [1:0]      outstanding;
   logic            spurious;

   ram_rr_arbiter #(
      .NrHosts(N), .AddrWidth(AW), .DataWidth(DW), .MaxOutstanding(MO)
   ) dut (
      .clk_i(clk), .rst_ni(rst_n),
      .host_req_i(host_req), .host_gnt_o(host_gnt),
      .host_addr_i(host_addr), .host_we_i(host_we), .host_be_i(host_be),
      .host_wdata_i(host_wdata), .host_rvalid_o(host_rvalid),
      .host_rdata_o(host_rdata), .host_err_o(host_err),
      .dev_req_o(dev_req), .dev_we_o(dev_we), .dev_addr_o(dev_addr),
      .dev_be_o(dev_be), .dev_wdata_o(dev_wdata),
      .dev_gnt_i(dev_gnt), .dev_rvalid_i(dev_rvalid), .dev_err_i(dev_err),
      .dev_rdata_i(dev_rdata),
      .outstanding_o(outstanding), .spurious_rsp_o(spurious)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] haddr(input int h);
      return 32'h1000_0000 + 32'(h) * 32'h10;
   endfunction
   function automatic logic [3:0] hbe(input int h);
      return 4'(h + 1);
   endfunction
   function automatic logic [31:0] hwdata(input int h);
      return 32'hCAFE_0000 + 32'(h);
   endfunction
   function automatic logic hwe(input int h);
      return (h % 2) == 1;
   endfunction

   // Reference model: queue of host indices awaiting responses, last grant, sticky flag.
   int mq[$];
   int m_last      = N - 1;
   bit m_spur      = 1'b0;
   bit model_valid = 1'b0;

   initial begin : compare
      int   sel;
      int   h;
      bit   e_req, do_pop, do_push, spur_set, rst_s;
      logic [N-1:0] e_gnt, e_rv, e_err;
      forever begin
         @(negedge clk);
         rst_s = rst_n;
         sel = -1;
         for (int k = 1; k <= N; k++) begin
            h = (m_last + k) % N;
            if (host_req[h] && sel < 0) sel = h;
         end
         e_req    = rst_s && (sel >= 0) && ((mq.size() < MO) || dev_rvalid);
         do_push  = e_req && dev_gnt;
         do_pop   = rst_s && dev_rvalid && (mq.size() > 0);
         spur_set = rst_s && dev_rvalid && (mq.size() == 0);
         e_gnt    = do_push ? N'(1 << sel) : '0;
         e_rv     = do_pop ? N'(1 << mq[0]) : '0;
         e_err    = (do_pop && dev_err) ? e_rv : '0;
         if (model_valid) begin
            check("m_dev_req", 32'(dev_req), 32'(e_req));
            check("m_dev_addr", dev_addr, e_req ? haddr(sel) : 32'h0);
            check("m_dev_we", 32'(dev_we), e_req ? 32'(hwe(sel)) : 32'h0);
            check("m_dev_be", 32'(dev_be), e_req ? 32'(hbe(sel)) : 32'h0);
            check("m_dev_wdata", dev_wdata, e_req ? hwdata(sel) : 32'h0);
            check("m_host_gnt", 32'(host_gnt), 32'(e_gnt));
            check("m_host_rvalid", 32'(host_rvalid), 32'(e_rv));
            check("m_host_err", 32'(host_err), 32'(e_err));
            check("m_host_rdata", host_rdata, do_pop ? dev_rdata : 32'h0);
            check("m_outstanding", 32'(outstanding), 32'(mq.size()));
            check("m_spurious", 32'(spurious), 32'(m_spur));
         end
         @(posedge clk);
         if (!rst_s) begin
            mq.delete();
            m_last      = N - 1;
            m_spur      = 1'b0;
            model_valid = 1'b1;
         end else if (model_valid) begin
            if (do_pop) void'(mq.pop_front());
            if (do_push) begin
               mq.push_back(sel);
               m_last = sel;
            end
            if (spur_set) m_spur = 1'b1;
         end
      end
   end

   // Inputs change just after the rising edge; returns at the following falling edge.
   task automatic apply(input logic rst, input logic [N-1:0] req, input logic gnt,
                        input logic rv, input logic err, input logic [31:0] rd);
      @(posedge clk);
      #1;
      rst_n      = rst;
      host_req   = req;
      dev_gnt    = gnt;
      dev_rvalid = rv;
      dev_err    = err;
      dev_rdata  = rd;
      @(negedge clk);
   endtask

   initial begin : stimulus
      logic [N-1:0] exp_g [6];
      exp_g = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
      for (int h = 0; h < N; h++) begin
         host_addr[h*AW +: AW]  = haddr(h);
         host_be[h*4 +: 4]      = hbe(h);
         host_wdata[h*DW +: DW] = hwdata(h);
         host_we[h]             = hwe(h);
      end

      // Outputs forced quiet while in reset.
      apply(0, 3'b111, 1, 1, 1, 32'h5555_5555);
      apply(0, 3'b111, 1, 1, 1, 32'h5555_5555);
      check("rst_dev_req", 32'(dev_req), 0);
      check("rst_host_gnt", 32'(host_gnt), 0);
      check("rst_host_rvalid", 32'(host_rvalid), 0);
      check("rst_host_rdata", host_rdata, 0);

      // All hosts requesting, one-cycle responses.
      for (int k = 0; k < 6; k++) begin
         apply(1, 3'b111, 1, k > 0, 0, 32'hA000_0000 + 32'(k));
         check("rr_gnt", 32'(host_gnt), 32'(exp_g[k]));
         if (k > 0) begin
            check("rr_rvalid", 32'(host_rvalid), 32'(exp_g[k-1]));
            check("rr_rdata", host_rdata, 32'hA000_0000 + 32'(k));
         end
      end
      check("rr_outstanding", 32'(outstanding), 1);
      apply(1, 3'b000, 1, 1, 0, 32'hB0);
      check("drain_rvalid", 32'(host_rvalid), 32'b100);

      // Two accepts fill the FIFO; a response reopens issue in the same cycle.
      apply(1, 3'b001, 1, 0, 0, 0);
      check("full_outst0", 32'(outstanding), 0);
      check("full_gnt0", 32'(host_gnt), 32'b001);
      apply(1, 3'b001, 1, 0, 0, 0);
      check("full_gnt1", 32'(host_gnt), 32'b001);
      apply(1, 3'b010, 1, 0, 0, 0);
      check("full_outst2", 32'(outstanding), 2);
      check("full_dev_req", 32'(dev_req), 0);
      check("full_no_gnt", 32'(host_gnt), 0);
      apply(1, 3'b010, 1, 1, 0, 32'hC1);
      check("full_rv_dev_req", 32'(dev_req), 1);
      check("full_rv_gnt", 32'(host_gnt), 32'b010);
      check("full_rv_rvalid", 32'(host_rvalid), 32'b001);
      apply(1, 3'b000, 0, 1, 0, 32'hC2);
      check("full_outst_hold", 32'(outstanding), 2);
      check("full_rvalid2", 32'(host_rvalid), 32'b001);
      apply(1, 3'b000, 0, 1, 0, 32'hC3);
      check("full_rvalid3", 32'(host_rvalid), 32'b010);

      // Stalled device: host 2's request held steady, no grant, pointer kept.
      for (int k = 0; k < 3; k++) begin
         apply(1, 3'b100, 0, 0, 0, 0);
         check("stall_dev_req", 32'(dev_req), 1);
         check("stall_addr", dev_addr, 32'h1000_0020);
         check("stall_no_gnt", 32'(host_gnt), 0);
      end
      apply(1, 3'b111, 1, 0, 0, 0);
      check("stall_ptr_kept", 32'(host_gnt), 32'b100);

      // Error response routed to host 1 only.
      apply(1, 3'b010, 1, 0, 0, 0);
      check("err_gnt", 32'(host_gnt), 32'b010);
      apply(1, 3'b000, 0, 1, 0, 32'hD0);
      check("err_rv0", 32'(host_rvalid), 32'b100);
      check("err_err0", 32'(host_err), 0);
      apply(1, 3'b000, 0, 1, 1, 32'hD1);
      check("err_rv1", 32'(host_rvalid), 32'b010);
      check("err_err1", 32'(host_err), 32'b010);
      apply(1, 3'b000, 0, 0, 0, 0);
      check("err_rv_clear", 32'(host_rvalid), 0);
      check("err_err_clear", 32'(host_err), 0);

      // Reset with two outstanding, then host 0 wins.
      apply(1, 3'b011, 1, 0, 0, 0);
      check("rst2_gnt0", 32'(host_gnt), 32'b001);
      apply(1, 3'b011, 1, 0, 0, 0);
      check("rst2_gnt1", 32'(host_gnt), 32'b010);
      apply(0, 3'b111, 1, 1, 0, 32'hEE);
      check("rst2_outst2", 32'(outstanding), 2);
      check("rst2_quiet_req", 32'(dev_req), 0);
      check("rst2_quiet_rv", 32'(host_rvalid), 0);
      apply(1, 3'b111, 1, 0, 0, 0);
      check("rst2_outst0", 32'(outstanding), 0);
      check("rst2_gnt_host0", 32'(host_gnt), 32'b001);

      // Response straight after reset is spurious and sticky.
      apply(0, 3'b000, 0, 0, 0, 0);
      apply(1, 3'b000, 0, 1, 0, 32'hE0);
      check("spur_before", 32'(spurious), 0);
      check("spur_no_rv", 32'(host_rvalid), 0);
      for (int k = 0; k < 3; k++) begin
         apply(1, 3'b000, 0, 0, 0, 0);
         check("spur_sticky", 32'(spurious), 1);
      end

      // Pending entry discarded by reset; its response becomes spurious.
      apply(1, 3'b001, 1, 0, 0, 0);
      check("disc_gnt", 32'(host_gnt), 32'b001);
      apply(0, 3'b000, 0, 0, 0, 0);
      apply(1, 3'b000, 0, 1, 0, 32'hE1);
      check("disc_spur_clr", 32'(spurious), 0);
      check("disc_no_rv", 32'(host_rvalid), 0);
      apply(1, 3'b000, 0, 0, 0, 0);
      check("disc_spur_set", 32'(spurious), 1);

      // Mixed patterned traffic, checked by the model.
      apply(0, 3'b000, 0, 0, 0, 0);
      for (int i = 0; i < 40; i++) begin
         apply(1, N'((i * 5 + 1) % 8), (i % 3) != 0, (i % 4) != 1, (i % 5) == 0,
               32'hF000_0000 + 32'(i));
      end
      apply(1, 3'b000, 0, 0, 0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/ram_rr_arbiter.md
RAM_RR_ARBITER -- requirements
Module: ram_rr_arbiter

Interface
REQ-001 SHALL have parameter NrHosts, default 3, number of requesting hosts (2..8).
REQ-002 SHALL have parameter AddrWidth, default 32, address width.
REQ-003 SHALL have parameter DataWidth, default 32, data width.
REQ-004 SHALL have parameter MaxOutstanding, default 2, response-order FIFO depth (1..8).
REQ-005 SHALL have clk_i  input  1  the only clock; all state changes on the rising edge.
REQ-006 SHALL have rst_ni  input  1  synchronous, active-low reset.
REQ-007 SHALL have host_req_i  input  NrHosts  per-host request.
REQ-008 SHALL have host_gnt_o  output  NrHosts  per-host grant.
REQ-009 SHALL have host_addr_i  input  NrHosts*AddrWidth  per-host address; host i occupies slice i.
REQ-010 SHALL have host_we_i  input  NrHosts  per-host write enable.
REQ-011 SHALL have host_be_i  input  NrHosts*4  per-host byte enables.
REQ-012 SHALL have host_wdata_i  input  NrHosts*DataWidth  per-host write data.
REQ-013 SHALL have host_rvalid_o  output  NrHosts  per-host response valid.
REQ-014 SHALL have host_rdata_o  output  DataWidth  shared response data.
REQ-015 SHALL have host_err_o  output  NrHosts  per-host response error.
REQ-016 SHALL have dev_req_o, dev_we_o  output  1 each; dev_addr_o  output  AddrWidth; dev_be_o  output  4; dev_wdata_o  output  DataWidth.
REQ-017 SHALL have dev_gnt_i, dev_rvalid_i, dev_err_i  input  1 each; dev_rdata_i  input  DataWidth.
REQ-018 SHALL have outstanding_o  output  $clog2(MaxOutstanding+1)  count of accepted, unanswered requests.
REQ-019 SHALL have spurious_rsp_o  output  1  sticky flag: response received with none outstanding.

Function
REQ-020 SHALL define issue_ok = (outstanding_o < MaxOutstanding) | dev_rvalid_i.
REQ-021 SHALL select the requesting host by round-robin, searching upward from rr_ptr+1 (mod NrHosts).
REQ-022 SHALL drive dev_req_o = (|host_req_i) & issue_ok and mux the selected host's addr/we/be/wdata onto dev_*; outputs SHALL be 0 when dev_req_o is 0.
REQ-023 SHALL assert host_gnt_o[i] combinationally only when i is selected & dev_req_o & dev_gnt_i; at most one grant bit per cycle.
REQ-024 SHALL on accept (dev_req_o & dev_gnt_i) set rr_ptr to the granted index and push that index into the order FIFO.
REQ-025 SHALL hold rr_ptr while dev_gnt_i is low, so the selection stays stable for a stalled host.
REQ-026 SHALL on dev_rvalid_i with FIFO non-empty pop the head and drive host_rvalid_o[head]=1, host_err_o[head]=dev_err_i in the same cycle; all other bits SHALL be 0.
REQ-027 SHALL pass dev_rdata_i to host_rdata_o when a response is routed, else drive 0.
REQ-028 SHALL on simultaneous push and pop keep outstanding_o unchanged, with FIFO order preserved; this is allowed when full.
REQ-029 SHALL on dev_rvalid_i with FIFO empty route nothing, leave the count at 0 and set spurious_rsp_o.
REQ-030 SHALL add zero cycles of latency in the request and response paths.
REQ-031 SHALL not allow outstanding_o to exceed MaxOutstanding or to underflow.

Reset
REQ-032 SHALL on rst_ni=0 at a clock edge set rr_ptr=NrHosts-1 (host 0 highest priority first), FIFO empty, outstanding_o=0 and spurious_rsp_o=0.
REQ-033 SHALL, when reset is asserted mid-transaction, discard pending entries; later dev_rvalid_i SHALL set spurious_rsp_o.
REQ-034 SHALL hold all combinational outputs at 0 while rst_ni=0, regardless of inputs.

Verification
REQ-035 SHALL cover: after reset, all 3 hosts request continuously with dev_gnt_i=1 and responses 1 cycle later -> grants in order 0,1,2,0,1,2; each host_rvalid_o matches its own grant.
REQ-036 SHALL cover: MaxOutstanding=2, two accepts, no response -> outstanding_o=2 and dev_req_o=0; dev_rvalid_i=1 with host 1 requesting -> dev_req_o=1, gnt to host 1, outstanding_o stays 2.
REQ-037 SHALL cover: host 2 requesting, dev_gnt_i low for 3 cycles -> dev_addr_o stable at host 2's address; no host_gnt_o; rr_ptr unchanged.
REQ-038 SHALL cover: dev_rvalid_i=1 with dev_err_i=1 for head=host 1 -> host_err_o=3'b010 and host_rvalid_o=3'b010 for one cycle.
REQ-039 SHALL cover: dev_rvalid_i=1 right after reset -> spurious_rsp_o=1 from the next cycle until the next reset; host_rvalid_o=0.
REQ-040 SHALL cover: rst_ni low for one cycle with outstanding_o=2 -> outstanding_o=0 and next grant goes to host 0.
